// File: rtl/ternary_memory.sv
// Word-addressed ternary memory behind the CPU memory port, with a word-serial
// loader that fills it from index 0 while the CPU port is locked out.
module ternary_memory #(
  parameter int WORD_SIZE     = 9,
  parameter int MEM_ADDR_SIZE = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [2*MEM_ADDR_SIZE-1:0] mem_address,
  input  logic [2*WORD_SIZE-1:0]     mem_write_data,
  input  logic                       mem_read,
  input  logic                       mem_write,
  output logic [2*WORD_SIZE-1:0]     mem_read_data,
  input  logic                       load_enable,
  input  logic                       load_valid,
  input  logic [2*WORD_SIZE-1:0]     load_data,
  output logic                       load_ready,
  output logic                       busy,
  output logic                       load_done,
  output logic                       addr_error,
  output logic [1:0]                 state_dbg
);

  localparam int DW    = 2 * WORD_SIZE;
  localparam int DEPTH = 3 ** MEM_ADDR_SIZE;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             need_low_q, need_low_d;
  logic [DW-1:0]    rd_q, rd_d;
  logic             err_q, err_d;

  logic [DW-1:0]    mem_q [DEPTH];
  logic             mem_we;
  logic [PTR_W-1:0] mem_waddr;
  logic [DW-1:0]    mem_wdata;

  logic             addr_ok;
  logic [PTR_W-1:0] cpu_index;
  int               addr_acc;
  int               addr_pw;

  // Balanced-ternary address to array index, offset so the most negative
  // address lands on index 0.
  always_comb begin
    addr_ok  = 1'b1;
    addr_acc = (DEPTH - 1) / 2;
    addr_pw  = 1;
    for (int i = 0; i < MEM_ADDR_SIZE; i++) begin
      case (mem_address[2*i +: 2])
        2'b01:   addr_acc = addr_acc + addr_pw;
        2'b10:   addr_acc = addr_acc - addr_pw;
        2'b11:   addr_ok  = 1'b0;
        default: ;
      endcase
      addr_pw = addr_pw * 3;
    end
    cpu_index = PTR_W'(addr_acc);
  end

  // Loader handshake: in LOAD, load_ready is high every cycle; a word is
  // consumed on any rising edge where load_valid && load_ready && load_enable.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    need_low_d = need_low_q;
    rd_d       = rd_q;
    err_d      = err_q;
    mem_we     = 1'b0;
    mem_waddr  = cpu_index;
    mem_wdata  = mem_write_data;
    case (state_q)
      ST_IDLE: begin
        if (!load_enable) need_low_d = 1'b0;
        if (load_enable && !need_low_q) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
        end
        if (mem_read || mem_write) begin
          if (!addr_ok) begin
            err_d = 1'b1;
          end else begin
            if (mem_write) mem_we = 1'b1;
            if (mem_read) rd_d = mem_write ? mem_write_data : mem_q[cpu_index];
          end
        end
      end
      ST_LOAD: begin
        if (!load_enable) begin
          state_d = ST_DONE;
        end else if (load_valid) begin
          mem_we    = 1'b1;
          mem_waddr = ptr_q;
          mem_wdata = load_data;
          ptr_d     = ptr_q + PTR_W'(1);
          if (ptr_q == LAST_IDX) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // A load that ends with load_enable still high must see it drop
        // before another load can start.
        need_low_d = load_enable;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      need_low_q <= 1'b0;
      rd_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      need_low_q <= need_low_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
    end
  end

  // Storage has no reset so contents survive a reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign mem_read_data = rd_q;
  assign addr_error    = err_q;
  assign busy          = (state_q == ST_LOAD);
  assign load_ready    = (state_q == ST_LOAD);
  assign load_done     = (state_q == ST_DONE);
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_ternary_memory.sv
// Directed bench for ternary_memory: read responses go through an expected
// queue checked by a monitor; status outputs are checked inline.
module tb_ternary_memory;
  localparam int AS = 4;
  localparam int DW = 18;
  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] mem_address = '0;
  logic [DW-1:0] mem_write_data = '0;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic [DW-1:0] mem_read_data;
  logic          load_enable = 1'b0;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          load_ready;
  logic          busy;
  logic          load_done;
  logic          addr_error;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;
  logic [DW-1:0] cur_rd = '0;
  logic          chk = 1'b0;
  logic          chk_pend = 1'b0;

  ternary_memory dut (
    .clock(clock), .reset(reset),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data),
    .load_enable(load_enable), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .busy(busy), .load_done(load_done),
    .addr_error(addr_error), .state_dbg(state_dbg)
  );

  // clock/reset
  always #5 clock = ~clock;

  // monitor: compare mem_read_data one edge after a checked request
  always @(posedge clock) chk_pend <= chk;

  always @(negedge clock) begin
    if (chk_pend) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_data: got %h but no expected value queued", mem_read_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mem_read_data !== mon_exp) begin
          errors++;
          $display("FAIL rd_data: got %h expected %h", mem_read_data, mon_exp);
        end
      end
    end
    if (load_done === 1'b1) done_cnt++;
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] enc_addr(input int a);
    logic [AW-1:0] r;
    int v;
    int m;
    r = '0;
    v = a;
    for (int i = 0; i < AS; i++) begin
      m = ((v % 3) + 3) % 3;
      case (m)
        0:       begin r[2*i +: 2] = 2'b00; v = v / 3; end
        1:       begin r[2*i +: 2] = 2'b01; v = (v - 1) / 3; end
        default: begin r[2*i +: 2] = 2'b10; v = (v + 1) / 3; end
      endcase
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] word(input int i);
    return DW'(i * 517 + 3);
  endfunction

  // driver tasks
  task automatic cpu(input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic rd,
                     input logic wr, input logic do_chk, input logic [DW-1:0] e);
    mem_address    = a;
    mem_write_data = wd;
    mem_read       = rd;
    mem_write      = wr;
    if (do_chk) begin
      exp_q.push_back(e);
      chk    = 1'b1;
      cur_rd = e;
    end
    @(negedge clock);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    chk       = 1'b0;
  endtask

  task automatic wr_word(input int a, input logic [DW-1:0] d);
    cpu(enc_addr(a), d, 1'b0, 1'b1, 1'b0, '0);
  endtask

  task automatic rd_word(input int a, input logic [DW-1:0] e);
    cpu(enc_addr(a), '0, 1'b1, 1'b0, 1'b1, e);
  endtask

  initial begin
    int start_done;
    logic [AW-1:0] bad_addr;

    // reset then idle
    #2 reset = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_rd_data", mem_read_data, '0);
    check("rst_busy", DW'(busy), '0);
    check("rst_load_ready", DW'(load_ready), '0);
    check("rst_load_done", DW'(load_done), '0);
    check("rst_addr_error", DW'(addr_error), '0);
    reset = 1'b1;
    @(negedge clock);

    // boundary writes and reads
    wr_word(0, 18'h15555);
    wr_word(-40, 18'h2AAAA);
    wr_word(40, 18'h05A5A);
    rd_word(-40, 18'h2AAAA);
    rd_word(40, 18'h05A5A);
    rd_word(0, 18'h15555);
    wr_word(13, 18'h3F00F);
    rd_word(13, 18'h3F00F);
    cpu(enc_addr(-40), 18'h11111, 1'b0, 1'b1, 1'b1, cur_rd);
    rd_word(-40, 18'h11111);

    // full 81-word load with gaps, CPU write and read attempted while busy
    load_enable = 1'b1;
    @(negedge clock);
    check("load_busy_enter", DW'(busy), DW'(1));
    check("load_ready_enter", DW'(load_ready), DW'(1));
    for (int i = 0; i < 81; i++) begin
      if (i % 9 == 4) begin
        load_valid = 1'b0;
        @(negedge clock);
        check("load_busy_gap", DW'(busy), DW'(1));
      end
      load_valid = 1'b1;
      load_data  = word(i);
      if (i == 20) begin
        mem_write = 1'b1; mem_address = enc_addr(5); mem_write_data = 18'h3FFFF;
      end
      if (i == 30) begin
        mem_read = 1'b1; mem_address = enc_addr(0); chk = 1'b1; exp_q.push_back(cur_rd);
      end
      @(negedge clock);
      mem_write = 1'b0; mem_read = 1'b0; chk = 1'b0;
      if (i == 40 || i == 79) check("load_busy_mid", DW'(busy), DW'(1));
    end
    load_valid = 1'b0;
    check("load_done_pulse", DW'(load_done), DW'(1));
    check("load_busy_done", DW'(busy), '0);
    repeat (3) begin
      @(negedge clock);
      check("no_rearm_busy", DW'(busy), '0);
    end
    load_enable = 1'b0;
    @(negedge clock);
    check("load_done_count", DW'(done_cnt), DW'(1));
    rd_word(-40, word(0));
    rd_word(0, word(40));
    rd_word(40, word(80));
    rd_word(5, word(45));

    // early abort after 5 words
    start_done  = done_cnt;
    load_enable = 1'b1;
    @(negedge clock);
    check("abort_busy", DW'(busy), DW'(1));
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1;
      load_data  = word(100 + i);
      @(negedge clock);
    end
    load_enable = 1'b0;
    load_valid  = 1'b1;
    load_data   = 18'h12345;
    @(negedge clock);
    load_valid = 1'b0;
    check("abort_done_pulse", DW'(load_done), DW'(1));
    @(negedge clock);
    check("abort_done_count", DW'(done_cnt - start_done), DW'(1));
    check("abort_busy_idle", DW'(busy), '0);
    for (int i = 0; i < 5; i++) rd_word(-40 + i, word(100 + i));
    rd_word(-35, word(5));

    // invalid address trit: dropped, read data held, error sticky
    bad_addr = enc_addr(0);
    bad_addr[1:0] = 2'b11;
    check("err_before", DW'(addr_error), '0);
    cpu(bad_addr, 18'h3C3C3, 1'b1, 1'b1, 1'b1, cur_rd);
    check("err_set", DW'(addr_error), DW'(1));
    rd_word(-1, word(39));
    rd_word(0, word(40));
    rd_word(1, word(41));
    check("err_sticky", DW'(addr_error), DW'(1));

    // simultaneous read and write: write-through
    cpu(enc_addr(10), 18'h2D2D2, 1'b1, 1'b1, 1'b1, 18'h2D2D2);
    rd_word(10, 18'h2D2D2);

    // reset clears status but not memory
    reset = 1'b0;
    @(negedge clock);
    check("rst2_rd_data", mem_read_data, '0);
    check("rst2_addr_error", DW'(addr_error), '0);
    check("rst2_busy", DW'(busy), '0);
    reset  = 1'b1;
    cur_rd = '0;
    @(negedge clock);
    rd_word(40, word(80));
    @(negedge clock);
    check("exp_q_drained", DW'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
